// File: rtl/mem_io_pkg.sv
// Shared pin map, FSM state type and constant pad direction for the user-memory responder.
package mem_io_pkg;

  localparam int unsigned IO_W      = 38;
  localparam int unsigned RD_EN_BIT = 0;
  localparam int unsigned WR_EN_BIT = 3;
  localparam int unsigned ADDR_LSB  = 5;
  localparam int unsigned WDATA_LSB = 8;
  localparam int unsigned RDATA_LSB = 16;
  localparam int unsigned VALID_BIT = 24;
  localparam int unsigned BUSY_BIT  = 25;
  localparam int unsigned ERR_BIT   = 26;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    HOLD
  } state_e;

  // Pads [26:16] are driven outputs, everything else stays an input.
  localparam logic [IO_W-1:0] IO_OEB = {11'h7ff, 11'h000, 16'hffff};

endpackage

// File: rtl/io_sync.sv
// Multi-stage flop synchroniser for asynchronous pad inputs.
module io_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/mem_io_responder.sv
// Pad-side responder: synchronised strobe/address/data pins drive reads and writes of an
// 8x8 register file, with rdata, valid, busy and err returned on registered output pads.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AW          = 3,
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);

  localparam int unsigned SW = DW + AW + 2;

  logic [SW-1:0] sync_in, sync_out;
  logic          rd_s, wr_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;

  assign sync_in = {io_in[WDATA_LSB +: DW], io_in[ADDR_LSB +: AW],
                    io_in[WR_EN_BIT], io_in[RD_EN_BIT]};

  logic unused_pads;
  assign unused_pads = ^{io_in[IO_W-1:WDATA_LSB+DW], io_in[4], io_in[2:1]};

  io_sync #(
    .WIDTH  (SW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (sync_in),
    .q   (sync_out)
  );

  assign rd_s    = sync_out[0];
  assign wr_s    = sync_out[1];
  assign addr_s  = sync_out[2 +: AW];
  assign wdata_s = sync_out[2+AW +: DW];

  state_e        state_q, state_d;
  logic          rd_hist_q, wr_hist_q;
  logic          pend_rd_q, pend_wr_q, pend_rd, pend_wr;
  logic          rise_rd, rise_wr;
  logic          enter_rd, enter_wr;
  logic          err_q, rd_valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [DW-1:0] mem_q [DEPTH];

  assign rise_rd = rd_s & ~rd_hist_q;
  assign rise_wr = wr_s & ~wr_hist_q;
  // A fresh edge is visible to the FSM in the same cycle it is detected.
  assign pend_rd = pend_rd_q | rise_rd;
  assign pend_wr = pend_wr_q | rise_wr;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pend_wr)      state_d = WRITE;
        else if (pend_rd) state_d = READ;
      end
      WRITE: begin
        if (pend_wr)      state_d = WRITE;
        else if (pend_rd) state_d = READ;
        else              state_d = IDLE;
      end
      READ: state_d = HOLD;
      HOLD: begin
        if (pend_wr)      state_d = WRITE;
        else if (pend_rd) state_d = READ;
        else if (!rd_s)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_wr = (state_d == WRITE);
  assign enter_rd = (state_d == READ);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      rd_hist_q  <= 1'b0;
      wr_hist_q  <= 1'b0;
      pend_rd_q  <= 1'b0;
      pend_wr_q  <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rd_hist_q <= rd_s;
      wr_hist_q <= wr_s;
      pend_rd_q <= pend_rd & ~enter_rd;
      pend_wr_q <= pend_wr & ~enter_wr;
      // Sticky: simultaneous edges, or a write edge merged into one still pending.
      if ((rise_wr && rise_rd) || (rise_wr && pend_wr_q)) err_q <= 1'b1;
      if (enter_wr || enter_rd) begin
        addr_q  <= addr_s;
        wdata_q <= wdata_s;
      end
      if (state_q == WRITE) mem_q[addr_q] <= wdata_q;
      if (state_q == READ) begin
        rdata_q    <= mem_q[addr_q];
        rd_valid_q <= 1'b1;
      end else if (state_q == HOLD && state_d != HOLD) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    io_out                   = '0;
    io_out[RDATA_LSB +: DW]  = rdata_q;
    io_out[VALID_BIT]        = rd_valid_q;
    io_out[BUSY_BIT]         = (state_q == WRITE) || (state_q == READ);
    io_out[ERR_BIT]          = err_q;
  end

  assign io_oeb = IO_OEB;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomised transactions on the pad bus, checked against an array-based
// model of the memory, the last read value and the sticky error flag.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [37:0] io_in, io_out, io_oeb;

  logic        rd_pad, wr_pad;
  logic [2:0]  addr_pad;
  logic [7:0]  wdata_pad;
  logic [37:0] junk;

  logic [7:0]  ref_mem [8];
  logic [7:0]  ref_rdata;
  logic        ref_err;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] exp_out(input logic valid, input logic busy);
    logic [37:0] e;
    e        = '0;
    e[23:16] = ref_rdata;
    e[24]    = valid;
    e[25]    = busy;
    e[26]    = ref_err;
    return e;
  endfunction

  task automatic drive();
    io_in      = junk;
    io_in[0]   = rd_pad;
    io_in[3]   = wr_pad;
    io_in[7:5] = addr_pad;
    io_in[15:8] = wdata_pad;
  endtask

  task automatic new_junk();
    logic [63:0] r;
    r    = {$urandom(), $urandom()};
    junk = r[37:0];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    ref_rdata = 8'h00;
    ref_err   = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    int busy_cnt;
    busy_cnt = 0;
    new_junk();
    addr_pad = a; wdata_pad = d; drive();
    @(negedge clk);
    wr_pad = 1'b1; drive();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (io_out[25]) busy_cnt++;
    end
    wr_pad = 1'b0; drive();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (io_out[25]) busy_cnt++;
    end
    ref_mem[a] = d;
    check("wr_busy_pulse", 64'(busy_cnt), 64'd1);
    check("wr_idle_out", 64'(io_out), 64'(exp_out(1'b0, 1'b0)));
  endtask

  task automatic do_read(input logic [2:0] a);
    int busy_cnt;
    busy_cnt = 0;
    new_junk();
    addr_pad = a; drive();
    @(negedge clk);
    rd_pad = 1'b1; drive();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (io_out[25]) busy_cnt++;
      if (k == 3) check("rd_valid_early", 64'(io_out[24]), 64'd0);
      if (k == 4) begin
        ref_rdata = ref_mem[a];
        check("rd_data_edge4", 64'(io_out), 64'(exp_out(1'b1, 1'b0)));
      end
    end
    rd_pad = 1'b0; drive();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (io_out[25]) busy_cnt++;
      if (k == 2) check("rd_valid_hold", 64'(io_out[24]), 64'd1);
      if (k == 3) check("rd_valid_drop", 64'(io_out[24]), 64'd0);
    end
    check("rd_busy_pulse", 64'(busy_cnt), 64'd1);
  endtask

  initial begin
    logic [37:0] exp_oeb;
    logic [7:0]  keep_rdata;
    bit          seen;

    rd_pad = 1'b0; wr_pad = 1'b0; addr_pad = '0; wdata_pad = '0; junk = '0;
    drive();
    model_reset();
    repeat (3) @(negedge clk);
    check("in_reset_out", 64'(io_out), 64'(exp_out(1'b0, 1'b0)));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out", 64'(io_out), 64'(exp_out(1'b0, 1'b0)));
    for (int i = 0; i < 38; i++) exp_oeb[i] = !(i >= 16 && i <= 26);
    check("oeb_const", 64'(io_oeb), 64'(exp_oeb));

    do_write(3'd1, 8'hFA);
    do_write(3'd3, 8'hEA);
    do_read(3'd1);
    do_read(3'd3);
    do_read(3'd5);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(1) == 1) do_write(3'($urandom_range(7)), 8'($urandom_range(255)));
      else                        do_read(3'($urandom_range(7)));
    end

    // Both strobes on the same cycle: write lands first, then the read sees it.
    addr_pad = 3'd2; wdata_pad = 8'h5A; drive();
    @(negedge clk);
    rd_pad = 1'b1; wr_pad = 1'b1; drive();
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      seen = io_out[24];
    end
    check("sim_valid_seen", 64'(seen), 64'd1);
    ref_mem[2] = 8'h5A; ref_rdata = 8'h5A; ref_err = 1'b1;
    check("sim_out", 64'(io_out), 64'(exp_out(1'b1, 1'b0)));
    repeat (15) @(negedge clk);
    rd_pad = 1'b0; wr_pad = 1'b0; drive();
    repeat (10) @(negedge clk);
    check("sim_err_sticky", 64'(io_out), 64'(exp_out(1'b0, 1'b0)));
    do_read(3'd2);

    // Reset while a write sits in WRITE, before its commit edge.
    addr_pad = 3'd4; wdata_pad = 8'h33; drive();
    @(negedge clk);
    wr_pad = 1'b1; drive();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = io_out[25];
    end
    check("rst_busy_seen", 64'(seen), 64'd1);
    #1 rst = 1'b1;
    model_reset();
    #1 check("rst_async_out", 64'(io_out), 64'(exp_out(1'b0, 1'b0)));
    @(negedge clk);
    wr_pad = 1'b0; drive();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_read(3'd4);
    do_read(3'd2);

    do_write(3'd6, 8'hC3);
    do_read(3'd6);
    keep_rdata = ref_rdata;
    // Address/data toggling with no strobes must be inert.
    for (int k = 0; k < 30; k++) begin
      new_junk();
      addr_pad = 3'($urandom_range(7)); wdata_pad = 8'($urandom_range(255)); drive();
      @(negedge clk);
      check("toggle_quiet", 64'(io_out), 64'(exp_out(1'b0, 1'b0)));
    end
    check("toggle_rdata_kept", 64'(io_out[23:16]), 64'(keep_rdata));
    do_read(3'd6);
    do_read(3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
